// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect control for the five-stage core, with redirect hold while a fetch is outstanding
module pipe_ctrl #(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_if_stall,
    input  logic        i_req_id_stall,
    input  logic        i_req_ex_stall,
    input  logic        i_req_mem_stall,
    input  logic        i_ex_redirect,
    input  logic [31:0] i_ex_target,
    input  logic        i_mem_trap,
    output logic [4:0]  o_stall,
    output logic        o_flush_if_id,
    output logic        o_flush_id_ex,
    output logic        o_flush_ex_mem,
    output logic        o_pc_redirect,
    output logic [31:0] o_pc_target,
    output logic [31:0] o_stall_cycles
);
    typedef enum logic {RUN, PEND} state_t;
    state_t      r_state;
    logic [31:0] r_pend_target;
    logic [31:0] r_stall_cycles;
    logic        w_trap, w_redir, w_pend, w_ifs, w_ids, w_exs, w_mems, w_event;
    logic [31:0] w_target;
    // Every request is qualified with !rst so reset forces all outputs low
    always_comb begin
        w_mems         = !rst && i_req_mem_stall;
        w_trap         = !rst && i_mem_trap && !i_req_mem_stall;
        w_pend         = !rst && r_state == PEND;
        w_redir        = !rst && r_state == RUN && i_ex_redirect && !i_req_ex_stall && !i_req_mem_stall && !w_trap;
        w_ifs          = !rst && i_req_if_stall;
        w_exs          = !rst && i_req_ex_stall && !w_trap;
        w_ids          = !rst && i_req_id_stall && !w_trap && !w_redir;
        w_event        = w_trap || w_redir;
        o_stall        = w_mems ? 5'b01111 : w_exs ? 5'b00111 : w_ids ? 5'b00011 : w_ifs ? 5'b00001 : 5'b00000;
        o_flush_if_id  = w_event || w_pend;
        o_flush_id_ex  = w_event;
        o_flush_ex_mem = w_trap;
        w_target       = w_trap ? TRAP_VEC : w_pend ? r_pend_target : i_ex_target;
        o_pc_redirect  = (w_event || w_pend) && !w_ifs;
        o_pc_target    = o_pc_redirect ? w_target : 32'd0;
        o_stall_cycles = r_stall_cycles;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_pend_target  <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else begin
            if (o_stall != 5'b00000) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_event && w_ifs) r_pend_target <= w_target;
            r_state <= ((w_event || w_pend) && w_ifs) ? PEND : RUN;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus a short hand-written sequence for pipe_ctrl
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifs = 1'b0, ids = 1'b0, exs = 1'b0, mems = 1'b0, exr = 1'b0, trap = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic [4:0]  stall;
    logic        f_if_id, f_id_ex, f_ex_mem, pcr;
    logic [31:0] pct, cnt;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .i_req_if_stall(ifs), .i_req_id_stall(ids), .i_req_ex_stall(exs), .i_req_mem_stall(mems),
        .i_ex_redirect(exr), .i_ex_target(tgt), .i_mem_trap(trap),
        .o_stall(stall), .o_flush_if_id(f_if_id), .o_flush_id_ex(f_id_ex), .o_flush_ex_mem(f_ex_mem),
        .o_pc_redirect(pcr), .o_pc_target(pct), .o_stall_cycles(cnt)
    );

    typedef struct {
        logic        rst, ifs, ids, exs, mems, exr, trap;
        logic [31:0] tgt;
        logic [4:0]  e_stall;
        logic [2:0]  e_fl;
        logic        e_pcr;
        logic [31:0] e_pct, e_cnt;
    } vec_t;
    vec_t v[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, fi, fd, fe, fm, xr, tr, input logic [31:0] t,
                       input logic [4:0] es, input logic [2:0] ef, input logic ep, input logic [31:0] et, ec);
        v.push_back('{r, fi, fd, fe, fm, xr, tr, t, es, ef, ep, et, ec});
    endtask

    initial begin
        //   rst if id ex mem exr trap tgt            stall     fl      pcr target         cnt
        add(1, 1, 0, 0, 1, 1, 1, 32'h100, 5'b00000, 3'b000, 0, 32'h0,   32'd0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 3'b000, 0, 32'h0,   32'd0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 3'b000, 0, 32'h0,   32'd0);
        add(0, 0, 1, 0, 0, 0, 0, 32'h0,   5'b00011, 3'b000, 0, 32'h0,   32'd0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 3'b000, 0, 32'h0,   32'd1);
        add(0, 1, 0, 0, 1, 0, 0, 32'h0,   5'b01111, 3'b000, 0, 32'h0,   32'd1);
        add(0, 1, 0, 0, 1, 0, 0, 32'h0,   5'b01111, 3'b000, 0, 32'h0,   32'd2);
        add(0, 1, 0, 0, 1, 0, 0, 32'h0,   5'b01111, 3'b000, 0, 32'h0,   32'd3);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 3'b000, 0, 32'h0,   32'd4);
        add(0, 0, 1, 0, 0, 1, 0, 32'h100, 5'b00000, 3'b110, 1, 32'h100, 32'd4);
        add(0, 1, 0, 0, 0, 1, 0, 32'h200, 5'b00001, 3'b110, 0, 32'h0,   32'd4);
        add(0, 1, 0, 0, 0, 1, 0, 32'h300, 5'b00001, 3'b100, 0, 32'h0,   32'd5);
        add(0, 1, 0, 0, 0, 0, 0, 32'h0,   5'b00001, 3'b100, 0, 32'h0,   32'd6);
        add(0, 1, 0, 0, 0, 0, 0, 32'h0,   5'b00001, 3'b100, 0, 32'h0,   32'd7);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 3'b100, 1, 32'h200, 32'd8);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 3'b000, 0, 32'h0,   32'd8);
        add(0, 1, 0, 0, 0, 1, 0, 32'h200, 5'b00001, 3'b110, 0, 32'h0,   32'd8);
        add(0, 1, 0, 0, 0, 0, 1, 32'h0,   5'b00001, 3'b111, 0, 32'h0,   32'd9);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 3'b100, 1, 32'h4,   32'd10);
        add(0, 0, 0, 0, 1, 0, 1, 32'h0,   5'b01111, 3'b000, 0, 32'h0,   32'd10);
        add(0, 0, 1, 1, 0, 1, 1, 32'h300, 5'b00000, 3'b111, 1, 32'h4,   32'd11);
        add(0, 0, 0, 1, 0, 1, 0, 32'h300, 5'b00111, 3'b000, 0, 32'h0,   32'd11);
        add(0, 1, 0, 0, 0, 1, 0, 32'h500, 5'b00001, 3'b110, 0, 32'h0,   32'd12);
        add(1, 1, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 3'b000, 0, 32'h0,   32'd13);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 3'b000, 0, 32'h0,   32'd0);
        add(0, 1, 0, 0, 0, 1, 0, 32'h600, 5'b00001, 3'b110, 0, 32'h0,   32'd0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h0,   5'b00000, 3'b111, 1, 32'h4,   32'd1);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 3'b000, 0, 32'h0,   32'd1);
        foreach (v[i]) begin
            @(negedge clk);
            rst = v[i].rst; ifs = v[i].ifs; ids = v[i].ids; exs = v[i].exs;
            mems = v[i].mems; exr = v[i].exr; trap = v[i].trap; tgt = v[i].tgt;
            #2;
            check("stall", i, {27'd0, stall}, {27'd0, v[i].e_stall});
            check("flush", i, {29'd0, f_if_id, f_id_ex, f_ex_mem}, {29'd0, v[i].e_fl});
            check("pc_redirect", i, {31'd0, pcr}, {31'd0, v[i].e_pcr});
            check("pc_target", i, pct, v[i].e_pct);
            check("stall_cycles", i, cnt, v[i].e_cnt);
        end
        // Fetch stall alone never redirects and accumulates one count per cycle
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rst = 0; ifs = 1; ids = 0; exs = 0; mems = 0; exr = 0; trap = 0;
            #2;
            check("seq_stall", 100 + k, {27'd0, stall}, 32'd1);
            check("seq_redirect", 100 + k, {31'd0, pcr}, 32'd0);
        end
        @(negedge clk);
        ifs = 0;
        #2;
        check("seq_cycles", 105, cnt, 32'd6);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #2;
        check("seq_reset_cycles", 106, cnt, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage RISC-V core. It collects stall requests from IF, ID, EX and MEM, a branch/jump redirect from EX, and a trap request from MEM. From these it drives the per-register stall vector, the flush strobes and the PC redirect. A two-state FSM holds a redirect pending while an instruction fetch is still outstanding, and a cycle counter records stalled cycles for performance monitoring.

## Interface
- TRAP_VEC, 32'h0000_0004: PC loaded on an accepted trap.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_if_stall  in  1  fetch outstanding (instruction memory wait)
- req_id_stall  in  1  load-use hazard in ID
- req_ex_stall  in  1  multi-cycle EX operation busy
- req_mem_stall  in  1  data memory wait
- ex_redirect  in  1  EX resolved taken branch/jump
- ex_target  in  32  redirect target PC
- mem_trap  in  1  MEM instruction raises trap
- stall  out  5  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb; 1 = hold register
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  load bubble into that register; overrides stall in the register
- pc_redirect  out  1  PC loads pc_target this edge
- pc_target  out  32  redirect PC
- stall_cycles  out  32  count of cycles with stall != 0

## Operation
- Stall vector, combinational, highest requesting stage wins:
  - req_mem_stall gives 01111.
  - req_ex_stall gives 00111.
  - req_id_stall gives 00011.
  - req_if_stall gives 00001.
  - No request gives 00000.
- A register with stall[k]=1 while stall[k+1]=0 leaves a bubble in register k+1. The pipeline registers implement that bubble.
- Trap acceptance: mem_trap && !req_mem_stall.
  - Asserts flush_if_id, flush_id_ex and flush_ex_mem.
  - Masks req_id_stall and req_ex_stall; only req_if_stall may still drive the stall vector.
  - Target is TRAP_VEC.
- Redirect acceptance: ex_redirect && !req_ex_stall && !req_mem_stall && no accepted trap.
  - Asserts flush_if_id and flush_id_ex.
  - Masks req_id_stall.
  - Target is ex_target.
- ex_redirect is ignored while EX or MEM is stalled; the EX instruction holds and reasserts it.
- FSM state RUN:
  - Accepted trap/redirect with !req_if_stall: pc_redirect=1, pc_target=target; stay in RUN.
  - Accepted trap/redirect with req_if_stall: latch target into pend_target, pc_redirect=0, go to PEND.
- FSM state PEND:
  - flush_if_id=1 every cycle, so the wrong-path fetch is discarded.
  - While req_if_stall=1: pc_redirect=0.
  - When req_if_stall=0: pc_redirect=1, pc_target=pend_target, go to RUN.
  - Accepted trap in PEND: overwrite pend_target with TRAP_VEC and assert flush_id_ex and flush_ex_mem that cycle. If req_if_stall=0 in that same cycle, redirect directly to TRAP_VEC.
  - ex_redirect is ignored in PEND, because EX holds a bubble or an older instruction.
- stall_cycles increments by 1 on any cycle with stall != 0 and wraps at 2^32.

## Timing
- stall, flush_*, pc_redirect and pc_target are combinational from the inputs and the FSM state, valid in the same cycle.
- state, pend_target and stall_cycles update on the rising edge of clk.
- Redirect latency in RUN: 0 cycles; the PC is loaded at the same edge.
- Redirect latency via PEND: the PC is loaded at the first edge where req_if_stall=0.
- Reset, while rst=1 and after release:
  - state=RUN, pend_target=0, stall_cycles=0.
  - stall=00000, all flush_*=0, pc_redirect=0, pc_target=0; all requests are ignored.
- Reset mid-PEND discards pend_target and issues no redirect.
- Simultaneous events:
  - Trap beats redirect.
  - req_mem_stall blocks both trap and redirect.
  - Flush beats stall inside a register.

## Test plan
- req_id_stall=1 for 1 cycle, no other requests -> stall=00011 that cycle, then 00000; stall_cycles=1.
- req_mem_stall=1 and req_if_stall=1 together for 3 cycles -> stall=01111 throughout; stall_cycles=3.
- ex_redirect=1, ex_target=0x100 with req_id_stall=1 -> stall=00000, flush_if_id=flush_id_ex=1, pc_redirect=1, pc_target=0x100 in the same cycle.
- ex_redirect=1, ex_target=0x200 with req_if_stall=1 for 4 cycles -> pc_redirect=0 and flush_if_id=1 through the stalled cycles; pc_redirect=1, pc_target=0x200 on the first cycle with req_if_stall=0; state back to RUN.
- From PEND(0x200), mem_trap=1 -> pc_target becomes TRAP_VEC=0x4 on fetch completion. Separately, mem_trap=1 with req_mem_stall=1 -> no flush, stall=01111.
- rst asserted in PEND -> all outputs 0; after release, req_if_stall dropping gives no redirect.
